pipe_stall_ctrl: RTL and testbench

Pipeline interlock controller for the 5-stage MIPS pipeline, placed beside the ALU forwarding unit in the ID/EX region. It detects load-use hazards that forwarding cannot cover, sequences the multi-cycle multiply/divide unit through a busy/countdown FSM, and stalls dependent HI/LO readers or new mult/div issues. It applies branch flushes, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline interlock: load-use and mult/div hazard stalls, branch flush,
// mult/div busy sequencer and saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter int STALLCNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IDEX_MemRead,
    input  logic [4:0]            IDEX_RegisterRt,
    input  logic [4:0]            IFID_RegisterRs,
    input  logic [4:0]            IFID_RegisterRt,
    input  logic                  IFID_MemWrite,
    input  logic                  IFID_ReadsHiLo,
    input  logic                  IFID_IsMD,
    input  logic                  MD_Start,
    input  logic                  MD_IsDiv,
    input  logic                  Branch_Taken,
    output logic                  PCWrite,
    output logic                  IFID_Write,
    output logic                  IDEX_Bubble,
    output logic                  IFID_Flush,
    output logic                  MD_Busy,
    output logic                  MD_Done,
    output logic [STALLCNT_W-1:0] Stall_Count
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [STALLCNT_W-1:0] r_stall_cnt;

    logic w_rt_hit;
    logic w_load_use;
    logic w_md_haz;
    logic w_stall;

    // A store of the loaded register is covered by mem-to-mem forwarding.
    assign w_rt_hit   = (IDEX_RegisterRt == IFID_RegisterRt) && !IFID_MemWrite;
    assign w_load_use = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
                        ((IDEX_RegisterRt == IFID_RegisterRs) || w_rt_hit);
    assign w_md_haz   = r_busy && (IFID_ReadsHiLo || IFID_IsMD);
    assign w_stall    = (w_load_use || w_md_haz) && !Branch_Taken;

    assign PCWrite     = !w_stall;
    assign IFID_Write  = !w_stall;
    assign IDEX_Bubble = w_stall || Branch_Taken;
    assign IFID_Flush  = Branch_Taken;

    assign MD_Busy     = r_busy;
    assign MD_Done     = r_done;
    assign Stall_Count = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (MD_Start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= MD_IsDiv ? DIV_LD : MULT_LD;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALLCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed hazard scenarios plus random stimulus
// against a cycle-count reference model.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_RegisterRt;
    logic [4:0]  IFID_RegisterRs;
    logic [4:0]  IFID_RegisterRt;
    logic        IFID_MemWrite;
    logic        IFID_ReadsHiLo;
    logic        IFID_IsMD;
    logic        MD_Start;
    logic        MD_IsDiv;
    logic        Branch_Taken;
    logic        PCWrite;
    logic        IFID_Write;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic        MD_Busy;
    logic        MD_Done;
    logic [15:0] Stall_Count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: remaining busy cycles, done pulse, stall total.
    int m_rem  = 0;
    bit m_done = 1'b0;
    int m_sc   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegisterRt(IDEX_RegisterRt),
        .IFID_RegisterRs(IFID_RegisterRs),
        .IFID_RegisterRt(IFID_RegisterRt),
        .IFID_MemWrite  (IFID_MemWrite),
        .IFID_ReadsHiLo (IFID_ReadsHiLo),
        .IFID_IsMD      (IFID_IsMD),
        .MD_Start       (MD_Start),
        .MD_IsDiv       (MD_IsDiv),
        .Branch_Taken   (Branch_Taken),
        .PCWrite        (PCWrite),
        .IFID_Write     (IFID_Write),
        .IDEX_Bubble    (IDEX_Bubble),
        .IFID_Flush     (IFID_Flush),
        .MD_Busy        (MD_Busy),
        .MD_Done        (MD_Done),
        .Stall_Count    (Stall_Count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        IDEX_MemRead    = 1'b0;
        IDEX_RegisterRt = 5'd0;
        IFID_RegisterRs = 5'd0;
        IFID_RegisterRt = 5'd0;
        IFID_MemWrite   = 1'b0;
        IFID_ReadsHiLo  = 1'b0;
        IFID_IsMD       = 1'b0;
        MD_Start        = 1'b0;
        MD_IsDiv        = 1'b0;
        Branch_Taken    = 1'b0;
    endtask

    function automatic bit exp_stall();
        bit lu;
        bit md;
        lu = IDEX_MemRead && IDEX_RegisterRt != 0 &&
             (IDEX_RegisterRt == IFID_RegisterRs ||
              (IDEX_RegisterRt == IFID_RegisterRt && !IFID_MemWrite));
        md = (m_rem > 0) && (IFID_ReadsHiLo || IFID_IsMD);
        return (lu || md) && !Branch_Taken;
    endfunction

    task automatic model_clear();
        m_rem  = 0;
        m_done = 1'b0;
        m_sc   = 0;
    endtask

    // Check mid-cycle, then advance the model across the rising edge.
    task automatic tick();
        bit st;
        @(negedge clk);
        st = exp_stall();
        chk("pcwrite", 32'(PCWrite), 32'(!st));
        chk("ifid_wr", 32'(IFID_Write), 32'(!st));
        chk("bubble", 32'(IDEX_Bubble), 32'(st || Branch_Taken));
        chk("flush", 32'(IFID_Flush), 32'(Branch_Taken));
        chk("busy", 32'(MD_Busy), 32'(m_rem > 0));
        chk("done", 32'(MD_Done), 32'(m_done));
        chk("scnt", 32'(Stall_Count), 32'(m_sc));
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (st && m_sc < 65535) m_sc++;
            m_done = (m_rem == 1);
            if (m_rem > 0) m_rem--;
            else if (MD_Start) m_rem = MD_IsDiv ? 32 : 4;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_clear();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        tick();
        chk("rst_busy", 32'(MD_Busy), 32'd0);
        chk("rst_done", 32'(MD_Done), 32'd0);
        chk("rst_scnt", 32'(Stall_Count), 32'd0);
        chk("rst_pcw", 32'(PCWrite), 32'd1);
        reset = 1'b0;
        tick();

        // Load-use on Rs: exactly one stalled cycle.
        IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd8; IFID_RegisterRs = 5'd8;
        #1;
        chk("lu_pcw", 32'(PCWrite), 32'd0);
        chk("lu_bub", 32'(IDEX_Bubble), 32'd1);
        tick();
        clear_in();
        tick();
        chk("lu_cnt", 32'(Stall_Count), 32'd1);

        // Store of loaded Rt and $zero are not hazards.
        IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd8; IFID_RegisterRt = 5'd8;
        IFID_MemWrite = 1'b1; IFID_RegisterRs = 5'd3;
        #1;
        chk("st_exempt", 32'(PCWrite), 32'd1);
        tick();
        IFID_MemWrite = 1'b0; IDEX_RegisterRt = 5'd0; IFID_RegisterRs = 5'd0;
        IFID_RegisterRt = 5'd0;
        #1;
        chk("zero_exempt", 32'(PCWrite), 32'd1);
        tick();
        clear_in();

        // Mult then mfhi held.
        do_reset();
        MD_Start = 1'b1; IFID_ReadsHiLo = 1'b1;
        tick();
        MD_Start = 1'b0;
        repeat (4) tick();
        chk("mul_done", 32'(MD_Done), 32'd1);
        chk("mul_pcw", 32'(PCWrite), 32'd1);
        chk("mul_cnt", 32'(Stall_Count), 32'd4);
        tick();
        clear_in();

        // Div, then back-to-back mult accepted after the done pulse.
        do_reset();
        MD_Start = 1'b1; MD_IsDiv = 1'b1; IFID_IsMD = 1'b1;
        tick();
        MD_Start = 1'b0;
        repeat (32) tick();
        chk("div_done", 32'(MD_Done), 32'd1);
        chk("div_cnt", 32'(Stall_Count), 32'd32);
        MD_Start = 1'b1; MD_IsDiv = 1'b0;
        tick();
        chk("mul2_busy", 32'(MD_Busy), 32'd1);
        MD_Start = 1'b0;
        repeat (5) tick();
        clear_in();

        // Branch during a HI/LO stall: flush wins, counter holds.
        do_reset();
        MD_Start = 1'b1; IFID_ReadsHiLo = 1'b1;
        tick();
        MD_Start = 1'b0; Branch_Taken = 1'b1;
        #1;
        chk("br_flush", 32'(IFID_Flush), 32'd1);
        chk("br_pcw", 32'(PCWrite), 32'd1);
        tick();
        chk("br_cnt", 32'(Stall_Count), 32'd0);
        Branch_Taken = 1'b0;
        repeat (4) tick();
        clear_in();

        // Reset in the middle of a divide.
        do_reset();
        MD_Start = 1'b1; MD_IsDiv = 1'b1; IFID_IsMD = 1'b1;
        tick();
        MD_Start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        model_clear();
        chk("mrst_busy", 32'(MD_Busy), 32'd0);
        chk("mrst_cnt", 32'(Stall_Count), 32'd0);
        tick();
        reset = 1'b0;
        repeat (30) tick();
        clear_in();

        // Continuous load-use stall until the counter saturates.
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd5; IFID_RegisterRt = 5'd5;
        repeat (65540) tick();
        chk("sat_cnt", 32'(Stall_Count), 32'hFFFF);
        clear_in();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            IDEX_MemRead    = ($urandom_range(0, 1) == 1);
            IDEX_RegisterRt = 5'($urandom_range(0, 3));
            IFID_RegisterRs = 5'($urandom_range(0, 3));
            IFID_RegisterRt = 5'($urandom_range(0, 3));
            IFID_MemWrite   = ($urandom_range(0, 3) == 0);
            IFID_ReadsHiLo  = ($urandom_range(0, 3) == 0);
            IFID_IsMD       = ($urandom_range(0, 3) == 0);
            MD_Start        = ($urandom_range(0, 5) == 0);
            MD_IsDiv        = ($urandom_range(0, 3) == 0);
            Branch_Taken    = ($urandom_range(0, 7) == 0);
            reset           = ($urandom_range(0, 299) == 0);
            if (reset) begin
                #1;
                model_clear();
            end
            tick();
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
